// File: rtl/isa_pkg.sv
// Register-class encodings shared by the issue-stage blocks.
// Pure constants: no logic, no latency and no backpressure.
package isa_pkg;
  localparam int RC_SCALAR = 0;
  localparam int RC_FP     = 1;
  localparam int RC_VEC    = 2;
endpackage

// File: rtl/sb_pending_bank.sv
// Pending-write counters for one register class. Updates land on the next edge and are never backpressured.
// o_nz/o_sat come from registered state; o_busy_nxt/o_underflow describe the update being applied this cycle.
module sb_pending_bank #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int DEC_W    = 3
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush_all,
  input  logic [NUM_REGS-1:0]            i_inc,
  input  logic [NUM_REGS-1:0][DEC_W-1:0] i_dec,
  output logic [NUM_REGS-1:0]            o_nz,
  output logic [NUM_REGS-1:0]            o_sat,
  output logic                           o_busy_nxt,
  output logic                           o_underflow
);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] r_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [NUM_REGS-1:0][SUM_W-1:0] w_sum;
  logic [NUM_REGS-1:0]            w_neg;

  always_comb begin
    w_sum     = '0;
    w_neg     = '0;
    w_cnt_nxt = '0;
    o_nz      = '0;
    o_sat     = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      // Two's-complement at SUM_W bits: the MSB flags a net decrement past zero.
      w_sum[r] = SUM_W'(r_cnt[r]) + SUM_W'(i_inc[r]) - SUM_W'(i_dec[r]);
      w_neg[r] = w_sum[r][SUM_W-1];
      if (w_neg[r]) begin
        w_cnt_nxt[r] = '0;
      end else if (w_sum[r] > SUM_W'(CNT_MAX)) begin
        w_cnt_nxt[r] = CNT_MAX;
      end else begin
        w_cnt_nxt[r] = w_sum[r][CNT_W-1:0];
      end
      o_nz[r]  = |r_cnt[r];
      o_sat[r] = (r_cnt[r] == CNT_MAX);
    end
  end

  assign o_busy_nxt  = !i_flush_all && (|w_cnt_nxt);
  assign o_underflow = !i_flush_all && (|w_neg);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_flush_all) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: rtl/pending_scoreboard.sv
// Counter-based pending-write scoreboard; stall is combinational from registered counters, busy_any/underflow_err registered.
// Issue is held off via stall on RAW or dest saturation; SB_WAW_STRICT_EN stalls on any outstanding dest write.
module pending_scoreboard
  import isa_pkg::*;
#(
  parameter int NUM_CLASSES = 3,
  parameter int NUM_REGS    = 32,
  parameter int NUM_SRC     = 3,
  parameter int NUM_WB      = 3,
  parameter int CNT_W       = 2,
  localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int REG_W      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [NUM_SRC-1:0]       issue_src_valid,
  input  logic [NUM_SRC*CLS_W-1:0] issue_src_class,
  input  logic [NUM_SRC*REG_W-1:0] issue_src,
  input  logic                     issue_rd_valid,
  input  logic [CLS_W-1:0]         issue_rd_class,
  input  logic [REG_W-1:0]         issue_rd,
  output logic                     stall,
  input  logic                     flush_rr,
  input  logic                     flush_rr_rd_valid,
  input  logic [CLS_W-1:0]         flush_rr_rd_class,
  input  logic [REG_W-1:0]         flush_rr_rd,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*CLS_W-1:0]  wb_class,
  input  logic [NUM_WB*REG_W-1:0]  wb_rd,
  input  logic                     flush_all,
  output logic                     busy_any,
  output logic                     underflow_err
);
  localparam int DEC_W = $clog2(NUM_WB + 2);

  logic [NUM_CLASSES-1:0][NUM_REGS-1:0]            w_nz;
  logic [NUM_CLASSES-1:0][NUM_REGS-1:0]            w_sat;
  logic [NUM_CLASSES-1:0][NUM_REGS-1:0]            w_trk;
  logic [NUM_CLASSES-1:0][NUM_REGS-1:0]            w_rd_hit;
  logic [NUM_CLASSES-1:0][NUM_REGS-1:0]            w_inc;
  logic [NUM_CLASSES-1:0][NUM_REGS-1:0][DEC_W-1:0] w_dec;
  logic [NUM_CLASSES-1:0]                          w_busy_nxt;
  logic [NUM_CLASSES-1:0]                          w_underflow;
  logic                                            w_raw;
  logic                                            w_dest_blk;
  logic                                            w_accept;
  logic                                            r_busy_any;
  logic                                            r_underflow_err;

  // Out-of-range classes/indices simply never match any (c, r) pair.
  always_comb begin
    w_trk    = '0;
    w_raw    = 1'b0;
    w_rd_hit = '0;
    w_dec    = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        w_trk[c][r] = !((c == RC_SCALAR) && (r == 0));
        for (int s = 0; s < NUM_SRC; s++) begin
          if (issue_src_valid[s] && (issue_src_class[s*CLS_W +: CLS_W] == CLS_W'(c)) &&
              (issue_src[s*REG_W +: REG_W] == REG_W'(r))) begin
            w_raw = w_raw | w_nz[c][r];
          end
        end
        w_rd_hit[c][r] = w_trk[c][r] && issue_rd_valid &&
                         (issue_rd_class == CLS_W'(c)) && (issue_rd == REG_W'(r));
        for (int p = 0; p < NUM_WB; p++) begin
          if (w_trk[c][r] && wb_valid[p] && (wb_class[p*CLS_W +: CLS_W] == CLS_W'(c)) &&
              (wb_rd[p*REG_W +: REG_W] == REG_W'(r))) begin
            w_dec[c][r] = w_dec[c][r] + DEC_W'(1);
          end
        end
        if (w_trk[c][r] && flush_rr && flush_rr_rd_valid &&
            (flush_rr_rd_class == CLS_W'(c)) && (flush_rr_rd == REG_W'(r))) begin
          w_dec[c][r] = w_dec[c][r] + DEC_W'(1);
        end
      end
    end
  end

`ifdef SB_WAW_STRICT_EN
  assign w_dest_blk = |(w_rd_hit & w_nz);
`else
  assign w_dest_blk = |(w_rd_hit & w_sat);
`endif

  assign stall    = issue_valid && (w_raw || w_dest_blk);
  assign w_accept = issue_valid && !stall;
  assign w_inc    = w_accept ? w_rd_hit : '0;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_bank
    sb_pending_bank #(
      .NUM_REGS (NUM_REGS),
      .CNT_W    (CNT_W),
      .DEC_W    (DEC_W)
    ) u_bank (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush_all (flush_all),
      .i_inc       (w_inc[c]),
      .i_dec       (w_dec[c]),
      .o_nz        (w_nz[c]),
      .o_sat       (w_sat[c]),
      .o_busy_nxt  (w_busy_nxt[c]),
      .o_underflow (w_underflow[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_any      <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_busy_any      <= |w_busy_nxt;
      r_underflow_err <= r_underflow_err | (|w_underflow);
    end
  end

  assign busy_any      = r_busy_any;
  assign underflow_err = r_underflow_err;
endmodule
